stbc_encoder: RTL and testbench

STBC_ENCODER -- requirements
Module: stbc_encoder

---
 rtl/stbc_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_stbc_encoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stbc_encoder.sv
// stbc_encoder
//   2x2 Alamouti space-time block encoder. Each accepted input block carries
//   two complex symbols s1 = xI1 + j*xQ1 and s2 = xI2 + j*xQ2. The block is
//   emitted as two output slots:
//     slot 0 : ant0 = s1,          ant1 = s2
//     slot 1 : ant0 = -conj(s2),   ant1 = conj(s1)
//   Negation saturates, so the most negative value maps to the most positive.
//   Input blocks go into a 2-entry FIFO. A block is popped only on the slot-1
//   handshake, so the head block stays stable across both of its slots.
//
//   Optional feature (macro STBC_TX_NORM_EN): every output sample is scaled by
//   K = 2^Q/sqrt(2). The scaling is applied after negation and does not change
//   the latency.
//
// Parameters
//   N         sample word width (signed two's complement)
//   Q         number of fractional bits
// Ports
//   clk       clock; all state updates on the rising edge
//   rstn      asynchronous active-low reset
//   in_valid  / in_ready   input block handshake
//   xI1, xQ1, xI2, xQ2     input symbol block (signed Q-format)
//   out_valid / out_ready  output slot handshake
//   out_slot              0 = first slot, 1 = second slot of the codeword
//   a0_r, a0_i, a1_r, a1_i antenna 0 / antenna 1 complex samples
//   blk_done              high during the slot-1 handshake cycle
module stbc_encoder #(
  parameter int N = 32,
  parameter int Q = 22
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] xI1,
  input  logic [N-1:0] xQ1,
  input  logic [N-1:0] xI2,
  input  logic [N-1:0] xQ2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_slot,
  output logic [N-1:0] a0_r,
  output logic [N-1:0] a0_i,
  output logic [N-1:0] a1_r,
  output logic [N-1:0] a1_i,
  output logic         blk_done
);

  typedef struct packed {
    logic [N-1:0] i1;
    logic [N-1:0] q1;
    logic [N-1:0] i2;
    logic [N-1:0] q2;
  } blk_t;

  typedef enum logic [1:0] {IDLE, SLOT0, SLOT1} state_t;

`ifdef STBC_TX_NORM_EN
  localparam bit NormEn = 1'b1;
`else
  localparam bit NormEn = 1'b0;
`endif

  // 2^Q/sqrt(2) truncated to an integer; this is 2965820 at Q=22.
  localparam real KReal = real'(64'd1 << Q) / 1.4142135623730951;
  localparam int  KInt  = $rtoi(KReal);
  localparam logic [2*N-1:0] KWide = (2*N)'(KInt);

  function automatic logic [N-1:0] neg_sat(input logic [N-1:0] x);
    logic [N-1:0] most_neg;
    most_neg = {1'b1, {(N-1){1'b0}}};
    return (x == most_neg) ? ~most_neg : -x;
  endfunction

  function automatic logic [N-1:0] scale(input logic [N-1:0] x);
    logic signed [2*N-1:0] prod;
    prod = $signed({{N{x[N-1]}}, x}) * $signed(KWide);
    return NormEn ? N'(prod >>> Q) : x;
  endfunction

  // ---------------------------------------------------------------- FIFO
  blk_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  state_t     state;

  blk_t in_blk;
  logic push;
  logic pop;

  assign in_blk   = {xI1, xQ1, xI2, xQ2};
  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = (state == SLOT1) && out_ready;
  assign blk_done = out_valid && out_slot && out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_blk;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------- slot datapath
  // On a slot-1 pop the next block is either the second FIFO entry, or the
  // block being pushed in the same cycle when only one entry was occupied.
  blk_t         head;
  blk_t         next_blk;
  blk_t         src0;
  logic         has_next;
  logic [N-1:0] s0_a0r, s0_a0i, s0_a1r, s0_a1i;
  logic [N-1:0] s1_a0r, s1_a0i, s1_a1r, s1_a1i;

  always_comb begin
    head     = mem[rd_ptr];
    has_next = (count == 2'd2) || push;
    next_blk = (count == 2'd2) ? mem[~rd_ptr] : in_blk;
    src0     = (state == SLOT1) ? next_blk : head;
    s0_a0r   = scale(src0.i1);
    s0_a0i   = scale(src0.q1);
    s0_a1r   = scale(src0.i2);
    s0_a1i   = scale(src0.q2);
    s1_a0r   = scale(neg_sat(head.i2));
    s1_a0i   = scale(head.q2);
    s1_a1r   = scale(head.i1);
    s1_a1i   = scale(neg_sat(head.q1));
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_slot  <= 1'b0;
      a0_r      <= '0;
      a0_i      <= '0;
      a1_r      <= '0;
      a1_i      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            state     <= SLOT0;
            out_valid <= 1'b1;
            out_slot  <= 1'b0;
            a0_r      <= s0_a0r;
            a0_i      <= s0_a0i;
            a1_r      <= s0_a1r;
            a1_i      <= s0_a1i;
          end
        end
        SLOT0: begin
          if (out_ready) begin
            state    <= SLOT1;
            out_slot <= 1'b1;
            a0_r     <= s1_a0r;
            a0_i     <= s1_a0i;
            a1_r     <= s1_a1r;
            a1_i     <= s1_a1i;
          end
        end
        SLOT1: begin
          if (out_ready) begin
            if (has_next) begin
              state    <= SLOT0;
              out_slot <= 1'b0;
              a0_r     <= s0_a0r;
              a0_i     <= s0_a0i;
              a1_r     <= s0_a1r;
              a1_i     <= s0_a1i;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_slot  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_slot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stbc_encoder.sv
// tb_stbc_encoder
//   Bench for stbc_encoder (N=32, Q=22). A reference model turns every
//   accepted input block into its two expected Alamouti slots. One compare
//   process checks each output handshake against that queue. It also checks
//   in_ready against the model's FIFO occupancy and checks that outputs hold
//   while stalled. Directed sections add hand-computed literal expectations.
module tb_stbc_encoder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] xI1 = '0, xQ1 = '0, xI2 = '0, xQ2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_slot;
  logic [31:0] a0_r, a0_i, a1_r, a1_i;
  logic        blk_done;

  int n_chk  = 0;
  int n_fail = 0;

  stbc_encoder #(.N(32), .Q(22)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .xI1(xI1), .xQ1(xQ1), .xI2(xI2), .xQ2(xQ2),
    .out_valid(out_valid), .out_ready(out_ready), .out_slot(out_slot),
    .a0_r(a0_r), .a0_i(a0_i), .a1_r(a1_r), .a1_i(a1_i),
    .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint neg(input longint x);
    if (x == -64'sd2147483648) return 64'sd2147483647;
    return -x;
  endfunction

  function automatic longint post(input longint x);
`ifdef STBC_TX_NORM_EN
    return (x * 64'sd2965820) >>> 22;
`else
    return x;
`endif
  endfunction

  // ------------------------------------------------------------ model
  typedef struct {
    longint a0r, a0i, a1r, a1i;
    bit     slot;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  bit          prev_stall = 1'b0;
  logic [31:0] p_a0r, p_a0i, p_a1r, p_a1i;
  logic        p_slot;
  int          occ;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      occ = (exp_q.size() + 1) / 2;
      chk("in_ready_vs_occupancy", longint'(in_ready), longint'(occ < 2));
      if (prev_stall) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_slot",  longint'(out_slot), longint'(p_slot));
        chk("hold_a0_r",  sx(a0_r), sx(p_a0r));
        chk("hold_a0_i",  sx(a0_i), sx(p_a0i));
        chk("hold_a1_r",  sx(a1_r), sx(p_a1r));
        chk("hold_a1_i",  sx(a1_i), sx(p_a1i));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", longint'(out_valid), 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("m_slot",     longint'(out_slot), longint'(e.slot));
          chk("m_a0_r",     sx(a0_r), e.a0r);
          chk("m_a0_i",     sx(a0_i), e.a0i);
          chk("m_a1_r",     sx(a1_r), e.a1r);
          chk("m_a1_i",     sx(a1_i), e.a1i);
          chk("m_blk_done", longint'(blk_done), longint'(e.slot));
        end else begin
          chk("blk_done_stalled", longint'(blk_done), 0);
        end
      end else begin
        chk("blk_done_idle", longint'(blk_done), 0);
      end
      prev_stall = out_valid && !out_ready;
      p_slot = out_slot;
      p_a0r = a0_r; p_a0i = a0_i; p_a1r = a1_r; p_a1i = a1_i;
      if (in_valid && in_ready) begin
        exp_q.push_back('{post(sx(xI1)), post(sx(xQ1)), post(sx(xI2)), post(sx(xQ2)), 1'b0});
        exp_q.push_back('{post(neg(sx(xI2))), post(sx(xQ2)), post(sx(xI1)), post(neg(sx(xQ1))), 1'b1});
      end
    end
  end

  // -------------------------------------------------------- stimulus
  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_block(input logic [31:0] i1, q1, i2, q2);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    xI1 = i1; xQ1 = q1; xI2 = i2; xQ2 = q2;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_accept", longint'(ok), 1);
  endtask

  task automatic wait_slot(input bit slot, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid && out_slot == slot) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", longint'(ok), 1);
  endtask

  function automatic logic [31:0] pattern(input int b, input int k);
    logic [31:0] v;
    v = 32'(b * 32'h01234567 + k * 32'h00ABCDEF) ^ 32'h5A5A0000;
    if (b == 3 && k == 2) v = 32'h7FFFFFFF;
    if (b == 5 && k == 3) v = 32'h80000000;
    if (b == 6 && k == 1) v = 32'h80000000;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int run, dones, cnt;
    bit alt_ok;

    // Reset state
    #7;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_slot",  longint'(out_slot), 0);
    chk("rst_blk_done",  longint'(blk_done), 0);
    chk("rst_a0_r", sx(a0_r), 0);
    chk("rst_a1_i", sx(a1_i), 0);
    #16 rstn = 1'b1;
    #1 chk("rst_in_ready", longint'(in_ready), 1);

    // Single block with literal expectations and latency
    sync();
    send_block(32'h00400000, 32'h00200000, 32'hFFF00000, 32'h00800000);
    @(negedge clk);
    chk("lat_not_yet_valid", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_valid", longint'(out_valid), 1);
    chk("s0_slot", longint'(out_slot), 0);
`ifdef STBC_TX_NORM_EN
    chk("norm_s0_a0_r", sx(a0_r), 2965820);
`endif
    chk("s0_a0_r", sx(a0_r), post(64'sd4194304));
    chk("s0_a0_i", sx(a0_i), post(64'sd2097152));
    chk("s0_a1_r", sx(a1_r), post(-64'sd1048576));
    chk("s0_a1_i", sx(a1_i), post(64'sd8388608));
    chk("s0_blk_done", longint'(blk_done), 0);
    @(negedge clk);
    chk("s1_slot", longint'(out_slot), 1);
    chk("s1_a0_r", sx(a0_r), post(64'sd1048576));
    chk("s1_a0_i", sx(a0_i), post(64'sd8388608));
    chk("s1_a1_r", sx(a1_r), post(64'sd4194304));
    chk("s1_a1_i", sx(a1_i), post(-64'sd2097152));
    chk("s1_blk_done", longint'(blk_done), 1);
    @(negedge clk);
    chk("single_done_idle", longint'(out_valid), 0);

    // Backpressure: stall SLOT1 for 5 cycles with two more blocks queued
    sync();
    fork
      begin
        send_block(32'h00100000, 32'h00200000, 32'h00300000, 32'h00400000);
        send_block(32'hFF000000, 32'h01000000, 32'h00050000, 32'hFFFB0000);
        send_block(32'h12345678, 32'hEDCBA988, 32'h00000001, 32'hFFFFFFFF);
      end
      begin
        wait_slot(1'b0, ok);
        chk("bp_first_slot0", longint'(ok), 1);
        @(posedge clk); #1 out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("bp_in_ready_full", longint'(in_ready), 0);
          chk("bp_slot1_shown",   longint'(out_slot), 1);
          chk("bp_blk_done_low",  longint'(blk_done), 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Saturating negation
    sync();
    send_block(32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000);
    wait_slot(1'b0, ok);
    chk("sat_see_slot0", longint'(ok), 1);
    chk("sat_s0_a0_i_unclipped", sx(a0_i), post(-64'sd2147483648));
    wait_slot(1'b1, ok);
    chk("sat_see_slot1", longint'(ok), 1);
    chk("sat_s1_a0_r", sx(a0_r), post(64'sd2147483647));
    chk("sat_s1_a1_i", sx(a1_i), post(64'sd2147483647));
    drain();

    // Streaming: 8 back-to-back blocks
    sync();
    run = 0; dones = 0; alt_ok = 1'b1;
    fork
      begin
        for (int b = 0; b < 8; b++)
          send_block(pattern(b, 0), pattern(b, 1), pattern(b, 2), pattern(b, 3));
      end
      begin
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (out_valid) begin
            ok = 1'b1;
            break;
          end
        end
        chk("stream_start", longint'(ok), 1);
        if (ok) begin
          for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid) run++;
            if (out_slot != k[0]) alt_ok = 1'b0;
            if (blk_done) dones++;
          end
        end
        chk("stream_valid_run", run, 16);
        chk("stream_slot_alternates", longint'(alt_ok), 1);
        chk("stream_blk_done_count", dones, 8);
        @(negedge clk);
        chk("stream_end_idle", longint'(out_valid), 0);
      end
    join
    drain();

    // Reset during SLOT0 with 2 blocks buffered
    sync();
    out_ready = 1'b0;
    send_block(32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000);
    send_block(32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000);
    @(negedge clk);
    chk("rst2_full_before", longint'(in_ready), 0);
    chk("rst2_slot0_before", longint'(out_valid && !out_slot), 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst2_out_valid", longint'(out_valid), 0);
    chk("rst2_out_slot",  longint'(out_slot), 0);
    chk("rst2_blk_done",  longint'(blk_done), 0);
    chk("rst2_a0_r", sx(a0_r), 0);
    chk("rst2_a0_i", sx(a0_i), 0);
    chk("rst2_a1_r", sx(a1_r), 0);
    chk("rst2_a1_i", sx(a1_i), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rstn = 1'b1;
    out_ready = 1'b1;
    #1 chk("rst2_in_ready", longint'(in_ready), 1);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("rst2_quiet_after_release", cnt, 0);

    // Resumes normally with fresh input
    sync();
    send_block(32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 32'hC0000000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
